// File: rtl/uart_pkg.sv
// Shared UART constants and the frame-parser state encoding.
package uart_pkg;

   typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHK} state_t;

   localparam logic [7:0] HEADER_DEF = 8'hAA;
   localparam int CLK_FREQ  = 100_000_000;
   localparam int BAUD_RATE = 9600;
   localparam int BIT_CYC   = CLK_FREQ / BAUD_RATE;
   // Ten byte times of ten bits each.
   localparam int TIMEOUT_CYC_DEF = 10 * 10 * BIT_CYC;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port, async read, zero outside depth.
module uart_frame_buf #(
   parameter int DEPTH = 16
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [4:0] waddr,
   input  logic [7:0] wdata,
   input  logic [3:0] raddr,
   output logic [7:0] rdata
);

   logic [DEPTH-1:0][7:0] mem;

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)                       mem[i] <= 8'd0;
         else if (we && waddr == 5'(i))  mem[i] <= wdata;
      end
   end

   always_comb begin
      rdata = 8'd0;
      for (int i = 0; i < DEPTH; i++)
         if (raddr == 4'(i)) rdata = mem[i];
   end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles header/length/payload/checksum frames from the uart_recv byte stream.
module uart_frame_parser
   import uart_pkg::*;
#(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] HEADER      = HEADER_DEF,
   parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       frame_valid,
   output logic [4:0] frame_len,
   output logic       err_chk,
   output logic       err_len,
   output logic       err_timeout,
   output logic       busy
);

   state_t      state, state_nxt;
   logic        prev_valid, accept;
   logic [4:0]  len_q, idx;
   logic [7:0]  chk;
   logic [20:0] gap;
   logic        gap_hit, len_ok;
   logic        ev_good, ev_chk, ev_len, ev_to, buf_we;

   assign accept  = in_valid & ~prev_valid;
   // An accepted byte on the limit cycle wins over the timeout.
   assign gap_hit = (state != HUNT) && !accept && (gap == 21'(TIMEOUT_CYC - 1));
   assign len_ok  = (in_data != 8'd0) && (32'(in_data) <= MAX_LEN);
   assign busy    = (state != HUNT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= HUNT;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (gap_hit) state_nxt = HUNT;
      else if (accept) begin
         case (state)
            HUNT:    if (in_data == HEADER) state_nxt = LEN;
            LEN:     state_nxt = len_ok ? PAYLOAD : HUNT;
            PAYLOAD: if (idx + 5'd1 == len_q) state_nxt = CHK;
            CHK:     state_nxt = HUNT;
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_comb begin
      ev_good = 1'b0;
      ev_chk  = 1'b0;
      ev_len  = 1'b0;
      ev_to   = gap_hit;
      buf_we  = 1'b0;
      case (state)
         LEN:     ev_len  = accept && !len_ok;
         PAYLOAD: buf_we  = accept && (32'(idx) < MAX_LEN);
         CHK: begin
            ev_good = accept && (in_data == chk);
            ev_chk  = accept && (in_data != chk);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_valid  <= 1'b0;
         len_q       <= 5'd0;
         idx         <= 5'd0;
         chk         <= 8'd0;
         gap         <= 21'd0;
         frame_len   <= 5'd0;
         frame_valid <= 1'b0;
         err_chk     <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         prev_valid  <= in_valid;
         gap         <= (state == HUNT || accept || gap_hit) ? 21'd0 : gap + 21'd1;
         frame_valid <= ev_good;
         err_chk     <= ev_chk;
         err_len     <= ev_len;
         err_timeout <= ev_to;
         if (ev_good) frame_len <= len_q;
         if (accept && state == LEN && len_ok) begin
            len_q <= in_data[4:0];
            idx   <= 5'd0;
            chk   <= in_data;
         end
         if (accept && state == PAYLOAD) begin
            chk <= chk ^ in_data;
            idx <= idx + 5'd1;
         end
      end
   end

   uart_frame_buf #(.DEPTH(MAX_LEN)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (buf_we),
      .waddr (idx),
      .wdata (in_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed frame sequences with an event scoreboard for uart_frame_parser.
module tb_uart_frame_parser;

   localparam int MAX_LEN = 16;
   localparam int TO      = 200;
   localparam int K_GOOD = 1, K_CHK = 2, K_LEN = 3, K_TO = 4, K_MULTI = 5;

   logic       clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic [3:0] rd_addr = 4'd0;
   logic [7:0] rd_data;
   logic       frame_valid, err_chk, err_len, err_timeout, busy;
   logic [4:0] frame_len;

   uart_frame_parser #(.MAX_LEN(MAX_LEN), .HEADER(8'hAA), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .frame_valid(frame_valid),
      .frame_len(frame_len), .err_chk(err_chk), .err_len(err_len),
      .err_timeout(err_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int flen;
      int n;
      logic [MAX_LEN-1:0][7:0] pl;
      int at;
   } exp_t;

   typedef struct {
      int kind;
      int flen;
      int at;
   } got_t;

   exp_t       exp_q[$];
   got_t       got_q[$];
   logic [7:0] seq[$];
   logic [7:0] pl_q[$];
   int tests = 0, fails = 0;
   int last_len = 0, last_acc = 0;

   // Log every cycle with a pulse; overlapping pulses become a distinct kind.
   always @(negedge clk) begin
      got_t g;
      logic [3:0] p;
      p = {frame_valid, err_chk, err_len, err_timeout};
      if (p != 4'd0) begin
         if ($countones(p) > 1) g.kind = K_MULTI;
         else if (frame_valid)  g.kind = K_GOOD;
         else if (err_chk)      g.kind = K_CHK;
         else if (err_len)      g.kind = K_LEN;
         else                   g.kind = K_TO;
         g.flen = int'(frame_len);
         g.at   = cyc;
         got_q.push_back(g);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int w);
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      last_acc = cyc;
      repeat (w - 1) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_seq(input int w);
      foreach (seq[i]) send_byte(seq[i], w);
   endtask

   task automatic push_exp(input int kind);
      exp_t e;
      e.kind = kind;
      e.at   = last_acc + ((kind == K_TO) ? TO : 0);
      e.n    = pl_q.size();
      e.pl   = '0;
      foreach (pl_q[i]) e.pl[i] = pl_q[i];
      if (kind == K_GOOD) last_len = pl_q.size();
      e.flen = last_len;
      exp_q.push_back(e);
   endtask

   task automatic check_next(input int bound);
      exp_t e;
      got_t g;
      int waited = 0;
      while (got_q.size() == 0 && waited < bound) begin
         @(negedge clk);
         waited++;
      end
      e = exp_q.pop_front();
      tests++;
      assert (got_q.size() != 0) else begin
         fails++;
         $error("FAIL evt_wait observed=none expected=kind%0d", e.kind);
      end
      if (got_q.size() != 0) begin
         g = got_q.pop_front();
         chk("evt_kind", g.kind, e.kind);
         chk("evt_frame_len", g.flen, e.flen);
         chk("evt_cycle", g.at, e.at);
         if (e.kind == K_GOOD) begin
            for (int i = 0; i < e.n; i++) begin
               rd_addr = 4'(i);
               #1;
               chk("payload", rd_data, e.pl[i]);
            end
            @(negedge clk);
         end
      end
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_frame_valid", frame_valid, 0);
      chk("rst_frame_len", frame_len, 0);
      chk("rst_err_chk", err_chk, 0);
      chk("rst_err_len", err_len, 0);
      chk("rst_err_timeout", err_timeout, 0);
      chk("rst_busy", busy, 0);
      rd_addr = 4'd15; #1;
      chk("rst_rd_data15", rd_data, 0);
      rst = 1'b1;
      @(negedge clk);

      // Good frame, with busy sampled before the checksum byte.
      seq = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33};
      send_seq(1);
      chk("busy_mid", busy, 1);
      seq = '{8'h03};
      send_seq(1);
      pl_q = '{8'h11, 8'h22, 8'h33};
      push_exp(K_GOOD);
      check_next(10);

      // Bad checksum keeps frame_len.
      seq = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
      send_seq(1);
      pl_q = {};
      push_exp(K_CHK);
      check_next(10);

      // Length zero and length above MAX_LEN.
      seq = '{8'hAA, 8'h00};
      send_seq(1);
      push_exp(K_LEN);
      check_next(10);
      seq = '{8'hAA, 8'h11};
      send_seq(1);
      push_exp(K_LEN);
      check_next(10);
      seq = '{8'hAA, 8'h01, 8'h7E, 8'h7F};
      send_seq(1);
      pl_q = '{8'h7E};
      push_exp(K_GOOD);
      check_next(10);

      // Leading garbage, then a payload containing the header value.
      seq = '{8'h55, 8'h00, 8'hAA, 8'h02, 8'hAA, 8'h55, 8'hFD};
      send_seq(1);
      pl_q = '{8'hAA, 8'h55};
      push_exp(K_GOOD);
      check_next(10);

      // Silence after a payload byte fires the timeout exactly at the limit.
      seq = '{8'hAA, 8'h02, 8'h11};
      send_seq(1);
      pl_q = {};
      push_exp(K_TO);
      check_next(TO + 20);
      seq = '{8'hAA, 8'h01, 8'h05, 8'h04};
      send_seq(1);
      pl_q = '{8'h05};
      push_exp(K_GOOD);
      check_next(10);

      // A byte landing on the last cycle before the limit keeps the frame alive.
      seq = '{8'hAA, 8'h02, 8'h11};
      send_seq(1);
      while (cyc < last_acc + TO - 1) @(negedge clk);
      send_byte(8'h22, 1);
      send_byte(8'h31, 1);
      pl_q = '{8'h11, 8'h22};
      push_exp(K_GOOD);
      check_next(10);

      // Reset mid-payload clears everything, including the buffer.
      seq = '{8'hAA, 8'h04, 8'h01, 8'h02};
      send_seq(1);
      rst = 1'b0;
      #1;
      last_len = 0;
      rd_addr = 4'd0; #1;
      chk("mid_rst_frame_len", frame_len, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rd_data0", rd_data, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Wide strobes: each 3-cycle level counts once.
      seq = '{8'hAA, 8'h02, 8'h10, 8'h20, 8'h32};
      send_seq(3);
      pl_q = '{8'h10, 8'h20};
      push_exp(K_GOOD);
      check_next(10);

      repeat (5) @(negedge clk);
      chk("no_extra_events", got_q.size(), 0);
      chk("no_missing_events", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Consumes the byte stream produced by uart_recv (valid/data) and assembles it into checksummed command frames. The frame format is: header byte, length byte, 1..MAX_LEN payload bytes, checksum byte. Payload bytes go into an internal buffer that downstream control logic reads by address after a frame_valid pulse. Malformed, corrupted and stalled frames are discarded, and each discard is flagged with an error pulse.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame; buffer depth.
HEADER, 8'hAA, frame start byte.
TIMEOUT_CYC, 1041600, maximum idle cycles between bytes inside a frame (~10 byte times at 9600 baud, 100 MHz).

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  asynchronous, active-low reset (0 = reset).
in_valid  input  1  byte strobe from uart_recv.
in_data  input  8  received byte, sampled when a byte is accepted.
rd_addr  input  4  payload buffer read address.
rd_data  output  8  buffer[rd_addr], combinational; 0 if rd_addr >= MAX_LEN.
frame_valid  output  1  one-cycle pulse when a good frame has been received.
frame_len  output  5  payload length of the last good frame; held until the next good frame.
err_chk  output  1  one-cycle pulse on checksum mismatch.
err_len  output  1  one-cycle pulse when the length byte is 0 or greater than MAX_LEN.
err_timeout  output  1  one-cycle pulse when an in-frame gap exceeds TIMEOUT_CYC.
busy  output  1  high whenever state != HUNT.

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-low. Reset may assert mid-frame and aborts the frame. Reset values: all outputs 0, state HUNT, counters 0, buffer contents 0, edge register 0.
- Byte accept: a byte is accepted on an in_valid rising edge (in_valid=1 and registered previous in_valid=0). A level held high for several cycles counts as exactly one byte.
- State HUNT:
  - Accepted byte == HEADER -> LEN.
  - Any other byte is ignored.
- State LEN:
  - Accepted byte L with 1 <= L <= MAX_LEN: store L, clear index and running checksum, load checksum with L, -> PAYLOAD.
  - Otherwise pulse err_len -> HUNT. The rejected byte is not re-examined as a header.
- State PAYLOAD:
  - Each accepted byte is written to buffer[index] and XORed into the checksum; index increments.
  - After the L-th byte -> CHK.
- State CHK:
  - Accepted byte == checksum: frame_len <= L, pulse frame_valid -> HUNT.
  - Otherwise pulse err_chk -> HUNT. frame_len is unchanged.
- Latency: frame_valid / err_* are registered. Each is high for exactly the one cycle after the edge on which the terminating byte is accepted.
- Timeout:
  - The gap counter clears on every accepted byte and in HUNT.
  - It increments in LEN, PAYLOAD and CHK.
  - When it reaches TIMEOUT_CYC: pulse err_timeout -> HUNT.
  - If a byte is accepted on the same cycle the counter would reach TIMEOUT_CYC, the byte wins and no timeout fires.
- Buffer ownership:
  - The buffer is overwritten from the first payload byte of the next frame onward.
  - The consumer must finish reading within 2 byte times (~208k cycles) of frame_valid.
  - Payload from a failed frame may be partially written. It is only meaningful after frame_valid.
- Pulse exclusivity: at most one of frame_valid, err_chk, err_len, err_timeout is high in any cycle.
- Widths: checksum is an 8-bit XOR. The index is 5 bits, so an index equal to MAX_LEN never writes the buffer. The gap counter is 21 bits.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (HUNT, LEN, PAYLOAD, CHK);
  - HEADER default;
  - CLK_FREQ / BAUD_RATE constants;
  - derived TIMEOUT_CYC default, also used by uart_recv and any future uart_send.
- One sub-module, uart_frame_buf: MAX_LEN x 8 register file with a single synchronous write port (we, waddr, wdata) and an async-read port. Its reset is also asynchronous, active-low.

Test Plan:
- Good frame: bytes AA 03 11 22 33 03 -> frame_valid one pulse, frame_len=3, rd_addr 0/1/2 -> 11/22/33, no err_*.
- Bad checksum: AA 03 11 22 33 04 -> err_chk one pulse, frame_valid stays 0, frame_len keeps its previous value.
- Bad length: AA 00, then AA 11 -> two err_len pulses. The next AA 01 7E 7F -> frame_valid, frame_len=1, rd_data[0]=7E.
- Leading garbage and header resync: 55 00 AA 02 AA 55 FD -> frame_valid, frame_len=2, payload AA 55 (0x02^0xAA^0x55=0xFD).
- Timeout and recovery: AA 02 11, then silence for TIMEOUT_CYC cycles -> err_timeout exactly at the limit, busy drops. A following good frame parses correctly. A byte arriving one cycle before the limit produces no timeout.
- Reset and strobe width: rst low mid-PAYLOAD -> all outputs 0, busy 0, good frame parses after release. in_valid held high 3 cycles per byte -> same result as single-cycle strobes.
